// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - mode encoding shared by the T flip-flop counter and its users
package tff_pkg;

  typedef logic [1:0] tff_mode_t;

  localparam tff_mode_t MODE_HOLD = 2'b00;
  localparam tff_mode_t MODE_UP   = 2'b01;
  localparam tff_mode_t MODE_DOWN = 2'b10;
  localparam tff_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with asynchronous active-low reset to rst_val
module tff_cell (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= rst_val;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - hold/up/down/load counter built from a bank of T cells
// with a configurable wrap value, a one-cycle wrap pulse and a sticky overflow flag
module tff_counter
  import tff_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  tff_mode_t        mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1) begin : g_bad_width
    $error("tff_counter: WIDTH must be at least 1");
  end
  if (64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("tff_counter: MAX_VAL does not fit in WIDTH bits");
  end
  if (RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("tff_counter: RST_VAL exceeds MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             wrap_nxt;

  always_comb begin
    nxt      = q;
    wrap_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          if (q == MAX_Q) begin
            nxt      = '0;
            wrap_nxt = 1'b1;
          end else begin
            nxt = q + ONE_Q;
          end
        end
        MODE_DOWN: begin
          if (q == '0) begin
            nxt      = MAX_Q;
            wrap_nxt = 1'b1;
          end else begin
            nxt = q - ONE_Q;
          end
        end
        MODE_LOAD: nxt = (load_val > MAX_Q) ? MAX_Q : load_val;
        default:   nxt = q;
      endcase
    end
  end

  // Only bits that differ between current and next value are toggled.
  assign t = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rstn    (rstn),
      .t       (t[i]),
      .rst_val (RST_Q[i]),
      .q       (q[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
      if (wrap_nxt) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - directed vector bench for tff_counter (WIDTH=4, MAX_VAL=9)
module tb_tff_counter;
  import tff_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  tff_mode_t  mode;
  logic [3:0] load_val;
  logic       clr_ovf;
  logic [3:0] q;
  logic       wrap;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string     name;
    logic      en;
    tff_mode_t mode;
    logic [3:0] load_val;
    logic      clr_ovf;
    logic [3:0] exp_q;
    logic      exp_wrap;
    logic      exp_ovf;
  } vec_t;

  vec_t vecs[$];

  tff_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .mode     (mode),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .q        (q),
    .wrap     (wrap),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] eq, input logic ew, input logic eo);
    n_checks += 3;
    if (q !== eq) begin
      n_errors++;
      $display("FAIL %s q: got %0d expected %0d", nm, q, eq);
    end
    if (wrap !== ew) begin
      n_errors++;
      $display("FAIL %s wrap: got %0b expected %0b", nm, wrap, ew);
    end
    if (ovf !== eo) begin
      n_errors++;
      $display("FAIL %s ovf: got %0b expected %0b", nm, ovf, eo);
    end
  endtask

  function automatic void add(input string nm, input logic e, input tff_mode_t m,
                              input logic [3:0] lv, input logic c,
                              input logic [3:0] eq, input logic ew, input logic eo);
    vec_t v;
    v.name = nm; v.en = e; v.mode = m; v.load_val = lv; v.clr_ovf = c;
    v.exp_q = eq; v.exp_wrap = ew; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic e, input tff_mode_t m, input logic [3:0] lv, input logic c);
    en = e; mode = m; load_val = lv; clr_ovf = c;
  endtask

  initial begin
    add("idle_after_rst", 1'b0, MODE_UP, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) add("up_step", 1'b1, MODE_UP, 4'd0, 1'b0, 4'(i), 1'b0, 1'b0);
    add("up_wrap",     1'b1, MODE_UP,   4'd0,  1'b0, 4'd0, 1'b1, 1'b1);
    add("down_wrap",   1'b1, MODE_DOWN, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1);
    add("down_8",      1'b1, MODE_DOWN, 4'd0,  1'b0, 4'd8, 1'b0, 1'b1);
    add("down_7",      1'b1, MODE_DOWN, 4'd0,  1'b0, 4'd7, 1'b0, 1'b1);
    add("load_sat12",  1'b1, MODE_LOAD, 4'd12, 1'b0, 4'd9, 1'b0, 1'b1);
    add("load_5",      1'b1, MODE_LOAD, 4'd5,  1'b0, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add("en0_hold", 1'b0, MODE_UP, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1);
    add("en0_noload",  1'b0, MODE_LOAD, 4'd3,  1'b0, 4'd5, 1'b0, 1'b1);
    add("load_sat15",  1'b1, MODE_LOAD, 4'd15, 1'b0, 4'd9, 1'b0, 1'b1);
    add("wrap_clr",    1'b1, MODE_UP,   4'd0,  1'b1, 4'd0, 1'b1, 1'b1);
    add("hold_clr",    1'b1, MODE_HOLD, 4'd0,  1'b1, 4'd0, 1'b0, 1'b0);
    add("down_rewrap", 1'b1, MODE_DOWN, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1);
    add("up_rewrap",   1'b1, MODE_UP,   4'd0,  1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) add("up_to_6", 1'b1, MODE_UP, 4'd0, 1'b0, 4'(i), 1'b0, 1'b1);

    rstn = 1'b0;
    drive(1'b0, MODE_HOLD, 4'd0, 1'b0);
    @(negedge clk);
    check("in_reset_1", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("in_reset_2", 4'd0, 1'b0, 1'b0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].load_val, vecs[i].clr_ovf);
      @(negedge clk);
      check(vecs[i].name, vecs[i].exp_q, vecs[i].exp_wrap, vecs[i].exp_ovf);
    end

    // Asynchronous reset between edges: q=6, ovf=1 must clear before any clock edge.
    #2 rstn = 1'b0;
    #1 check("async_rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_held_up", 4'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    drive(1'b1, MODE_UP, 4'd0, 1'b0);
    @(negedge clk);
    check("resume_up", 4'd1, 1'b0, 1'b0);
    drive(1'b1, MODE_DOWN, 4'd0, 1'b0);
    @(negedge clk);
    check("switch_down", 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
